// File: rtl/gate_driver_reset_multi.sv
// Per-channel gate-driver reset sequencer: pulse, settle, fault check, retries, lockout.
// Optional GATE_DRIVER_FAULT_LATCH_EN adds a sticky per-channel fault_latched output.
module gate_driver_reset_multi #(
  parameter int unsigned clk_freq_hz   = 50_000_000,
  parameter int unsigned channels      = 2,
  parameter int unsigned fast_reset_us = 1,
  parameter int unsigned slow_reset_us = 5,
  parameter int unsigned settle_us     = 2,
  parameter int unsigned max_retries   = 3,
  localparam int unsigned RW = (max_retries > 0) ? $clog2(max_retries + 1) : 1
) (
  input  logic                     sys_clk,
  input  logic                     reset_n,
  input  logic [channels-1:0]      driver_enable,
  output logic [channels-1:0]      driver_enable_out,
  input  logic [channels-1:0]      reset_start,
  input  logic [channels-1:0]      slow_reset,
  input  logic [channels-1:0]      fault_n,
  input  logic                     auto_retry_en,
  input  logic [channels-1:0]      clear_lockout,
  output logic [channels-1:0]      reset_done,
  output logic [channels-1:0]      busy,
  output logic [channels-1:0]      locked_out,
`ifdef GATE_DRIVER_FAULT_LATCH_EN
  output logic [channels-1:0]      fault_latched,
`endif
  output logic [channels*RW-1:0]   retry_count
);

  localparam int unsigned CYC_US  = clk_freq_hz / 1_000_000;
  localparam int unsigned F_CYC   = fast_reset_us * CYC_US;
  localparam int unsigned S_CYC   = slow_reset_us * CYC_US;
  localparam int unsigned W_CYC   = settle_us * CYC_US;
  localparam int unsigned MAX_FS  = (F_CYC > S_CYC) ? F_CYC : S_CYC;
  localparam int unsigned MAX_CYC = (MAX_FS > W_CYC) ? MAX_FS : W_CYC;
  localparam int unsigned CW      = (MAX_CYC > 0) ? $clog2(MAX_CYC + 1) : 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PULSE,
    ST_SETTLE,
    ST_LOCKOUT
  } state_e;

  for (genvar i = 0; i < channels; i++) begin : g_ch
    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            done_q, done_d;
    logic [RW-1:0]   rc_q, rc_d;
    logic            check_w;
    logic [CW-1:0]   load_w;

    assign load_w = slow_reset[i] ? CW'(S_CYC) : CW'(F_CYC);

    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      done_d  = done_q;
      rc_d    = rc_q;
      check_w = 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (reset_start[i]) begin
            state_d = ST_PULSE;
            cnt_d   = load_w;
            done_d  = 1'b0;
            rc_d    = '0;
          end else if (auto_retry_en && !fault_n[i]) begin
            done_d = 1'b0;
            if (rc_q == RW'(max_retries)) begin
              state_d = ST_LOCKOUT;
            end else begin
              state_d = ST_PULSE;
              cnt_d   = CW'(S_CYC);
              rc_d    = rc_q + 1'b1;
            end
          end
        end
        ST_PULSE: begin
          // Exit on the edge where the counter would hit zero so the pulse is exactly F/S cycles
          if (reset_start[i]) begin
            cnt_d = load_w;
          end else if (cnt_q <= CW'(1)) begin
            if (W_CYC == 0) begin
              cnt_d   = '0;
              check_w = 1'b1;
            end else begin
              state_d = ST_SETTLE;
              cnt_d   = CW'(W_CYC);
            end
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        ST_SETTLE: begin
          if (reset_start[i]) begin
            state_d = ST_PULSE;
            cnt_d   = load_w;
          end else if (cnt_q <= CW'(1)) begin
            cnt_d   = '0;
            check_w = 1'b1;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        ST_LOCKOUT: begin
          if (clear_lockout[i]) begin
            state_d = ST_IDLE;
            rc_d    = '0;
            done_d  = 1'b0;
          end
        end
        default: state_d = ST_IDLE;
      endcase

      if (check_w) begin
        if (fault_n[i]) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else if (auto_retry_en && (rc_q < RW'(max_retries))) begin
          state_d = ST_PULSE;
          cnt_d   = CW'(S_CYC);
          rc_d    = rc_q + 1'b1;
        end else begin
          state_d = ST_LOCKOUT;
        end
      end
    end

    always_ff @(posedge sys_clk or negedge reset_n) begin
      if (!reset_n) begin
        state_q <= ST_IDLE;
        cnt_q   <= '0;
        done_q  <= 1'b0;
        rc_q    <= '0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        done_q  <= done_d;
        rc_q    <= rc_d;
      end
    end

    assign driver_enable_out[i]    = (state_q == ST_IDLE) && driver_enable[i];
    assign busy[i]                 = (state_q == ST_PULSE) || (state_q == ST_SETTLE);
    assign locked_out[i]           = (state_q == ST_LOCKOUT);
    assign reset_done[i]           = done_q;
    assign retry_count[i*RW +: RW] = rc_q;

`ifdef GATE_DRIVER_FAULT_LATCH_EN
    // A fault present in the same cycle as the clear keeps the latch set
    logic flt_q;
    always_ff @(posedge sys_clk or negedge reset_n) begin
      if (!reset_n) begin
        flt_q <= 1'b0;
      end else if (!fault_n[i]) begin
        flt_q <= 1'b1;
      end else if (clear_lockout[i]) begin
        flt_q <= 1'b0;
      end
    end
    assign fault_latched[i] = flt_q;
`endif
  end

endmodule

// File: tb/tb_gate_driver_reset_multi.sv
// Directed bench for gate_driver_reset_multi: default instance plus a settle_us=0 instance
// sharing stimulus; expectations are queued with their due cycle and checked on the falling edge.
module tb_gate_driver_reset_multi;

  localparam int F = 50;
  localparam int S = 250;
  localparam int W = 100;

  logic       sys_clk = 1'b0;
  logic       reset_n;
  logic [1:0] driver_enable, reset_start, slow_reset, fault_n, clear_lockout;
  logic       auto_retry_en;
  logic [1:0] out_a, done_a, busy_a, lock_a;
  logic [3:0] rc_a;
  logic [1:0] out_b, done_b, busy_b, lock_b;
  logic [3:0] rc_b;
`ifdef GATE_DRIVER_FAULT_LATCH_EN
  logic [1:0] flt_a, flt_b;
`endif

  always #5 sys_clk = ~sys_clk;

  gate_driver_reset_multi u_dut (
    .sys_clk(sys_clk), .reset_n(reset_n),
    .driver_enable(driver_enable), .driver_enable_out(out_a),
    .reset_start(reset_start), .slow_reset(slow_reset), .fault_n(fault_n),
    .auto_retry_en(auto_retry_en), .clear_lockout(clear_lockout),
    .reset_done(done_a), .busy(busy_a), .locked_out(lock_a),
`ifdef GATE_DRIVER_FAULT_LATCH_EN
    .fault_latched(flt_a),
`endif
    .retry_count(rc_a)
  );

  gate_driver_reset_multi #(.settle_us(0)) u_dut0 (
    .sys_clk(sys_clk), .reset_n(reset_n),
    .driver_enable(driver_enable), .driver_enable_out(out_b),
    .reset_start(reset_start), .slow_reset(slow_reset), .fault_n(fault_n),
    .auto_retry_en(auto_retry_en), .clear_lockout(clear_lockout),
    .reset_done(done_b), .busy(busy_b), .locked_out(lock_b),
`ifdef GATE_DRIVER_FAULT_LATCH_EN
    .fault_latched(flt_b),
`endif
    .retry_count(rc_b)
  );

  // sel: 0 out, 1 done, 2 busy, 3 locked, 4 retry_count (default DUT); 5 out, 6 done (W=0 DUT)
  typedef struct {
    int         cyc;
    int         sel;
    logic [3:0] exp;
    string      tag;
  } exp_t;

  exp_t sb[$];
  int   cyc    = 0;
  int   errors = 0;
  int   checks = 0;

  function automatic logic [3:0] observe(int sel);
    case (sel)
      0:       return {2'b00, out_a};
      1:       return {2'b00, done_a};
      2:       return {2'b00, busy_a};
      3:       return {2'b00, lock_a};
      4:       return rc_a;
      5:       return {2'b00, out_b};
      6:       return {2'b00, done_b};
      default: return 4'bxxxx;
    endcase
  endfunction

  task automatic check(input int sel, input logic [3:0] exp, input string tag);
    logic [3:0] got;
    got = observe(sel);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b at cycle %0d", tag, got, exp, cyc);
    end
  endtask

  task automatic expect_at(input int d, input int sel, input logic [3:0] exp, input string tag);
    exp_t e;
    e.cyc = cyc + d;
    e.sel = sel;
    e.exp = exp;
    e.tag = tag;
    sb.push_back(e);
  endtask

  task automatic expect_span(input int d0, input int d1, input int sel,
                             input logic [3:0] exp, input string tag);
    for (int d = d0; d <= d1; d++) expect_at(d, sel, exp, tag);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge sys_clk);
      cyc++;
      @(negedge sys_clk);
      for (int k = sb.size() - 1; k >= 0; k--) begin
        if (sb[k].cyc == cyc) begin
          check(sb[k].sel, sb[k].exp, sb[k].tag);
          sb.delete(k);
        end
      end
    end
  endtask

  initial begin
    reset_n       = 1'b0;
    driver_enable = 2'b00;
    reset_start   = 2'b00;
    slow_reset    = 2'b00;
    fault_n       = 2'b11;
    clear_lockout = 2'b00;
    auto_retry_en = 1'b0;
    tick(2);
    check(0, 4'b0000, "rst_out");
    check(1, 4'b0000, "rst_done");
    check(2, 4'b0000, "rst_busy");
    check(3, 4'b0000, "rst_lock");
    check(4, 4'b0000, "rst_rc");
    reset_n = 1'b1;
    tick(2);

    // Passthrough in IDLE, same cycle
    driver_enable = 2'b01;
    #1 check(0, 4'b0001, "pass_ch0");
    driver_enable = 2'b11;
    #1 check(0, 4'b0011, "pass_both");
    check(2, 4'b0000, "pass_busy");
    check(3, 4'b0000, "pass_lock");
    tick(1);

    // Fast reset on ch0
    slow_reset  = 2'b00;
    reset_start = 2'b01;
    expect_span(1, F, 5, 4'b0010, "fast_w0_low");
    expect_at(F + 1, 5, 4'b0011, "fast_w0_release");
    expect_at(F, 6, 4'b0000, "fast_w0_done_early");
    expect_at(F + 1, 6, 4'b0001, "fast_w0_done");
    expect_span(1, F + W, 0, 4'b0010, "fast_low");
    expect_at(F + W + 1, 0, 4'b0011, "fast_release");
    expect_at(F + W + 1, 1, 4'b0001, "fast_done");
    expect_at(F, 2, 4'b0001, "fast_busy");
    expect_at(F + W + 1, 2, 4'b0000, "fast_busy_end");
    tick(1);
    reset_start = 2'b00;
    tick(F + W + 9);

    // Slow reset with settle on ch0
    slow_reset  = 2'b01;
    reset_start = 2'b01;
    expect_at(1, 1, 4'b0000, "slow_done_clr");
    expect_span(1, S + W, 0, 4'b0010, "slow_low");
    expect_at(S + W, 1, 4'b0000, "slow_done_early");
    expect_at(S + W + 1, 0, 4'b0011, "slow_release");
    expect_at(S + W + 1, 1, 4'b0001, "slow_done");
    expect_at(S, 5, 4'b0010, "slow_w0_low");
    expect_at(S + 1, 6, 4'b0001, "slow_w0_done");
    tick(1);
    reset_start = 2'b00;
    slow_reset  = 2'b00;
    tick(S + W + 9);

    // Retry path on ch1: fast start, three slow retries, then lockout
    fault_n       = 2'b01;
    auto_retry_en = 1'b1;
    reset_start   = 2'b10;
    expect_span(1, F + W + 3 * (S + W), 0, 4'b0001, "retry_low");
    expect_at(1, 4, 4'b0000, "retry_rc0");
    expect_at(F + W, 4, 4'b0000, "retry_rc0_end");
    expect_at(F + W + 1, 4, 4'b0100, "retry_rc1");
    expect_at(F + W + (S + W), 4, 4'b0100, "retry_rc1_end");
    expect_at(F + W + (S + W) + 1, 4, 4'b1000, "retry_rc2");
    expect_at(F + W + 2 * (S + W) + 1, 4, 4'b1100, "retry_rc3");
    expect_at(F + W + 3 * (S + W), 3, 4'b0000, "retry_lock_early");
    expect_at(F + W + 3 * (S + W), 2, 4'b0010, "retry_busy");
    expect_at(F + W + 3 * (S + W) + 1, 3, 4'b0010, "retry_lock");
    expect_at(F + W + 3 * (S + W) + 1, 2, 4'b0000, "retry_busy_end");
    expect_at(F + W + 3 * (S + W) + 1, 0, 4'b0001, "retry_out");
    expect_at(F + W + 3 * (S + W) + 1, 4, 4'b1100, "retry_rc_sat");
    expect_at(F + W + 3 * (S + W) + 1, 1, 4'b0001, "retry_done");
    tick(1);
    reset_start = 2'b00;
    tick(F + W + 3 * (S + W) + 9);

    // Lockout ignores fault and start; clear releases ch1, no effect on idle ch0
    fault_n     = 2'b11;
    reset_start = 2'b10;
    expect_at(1, 3, 4'b0010, "lock_ignore_start");
    expect_at(1, 2, 4'b0000, "lock_no_busy");
    tick(1);
    reset_start = 2'b00;
    tick(2);
    check(3, 4'b0010, "lock_hold");
    clear_lockout = 2'b11;
    expect_at(1, 3, 4'b0000, "clr_lock");
    expect_at(1, 4, 4'b0000, "clr_rc");
    expect_at(1, 0, 4'b0011, "clr_out");
    expect_at(1, 1, 4'b0001, "clr_done_ch0_kept");
    tick(1);
    clear_lockout = 2'b00;
    tick(2);

    // Fault-triggered slow reset from IDLE on ch0
    fault_n = 2'b10;
    expect_at(1, 4, 4'b0001, "auto_rc1");
    expect_at(1, 2, 4'b0001, "auto_busy");
    expect_at(1, 1, 4'b0000, "auto_done_clr");
    expect_span(1, S + W, 0, 4'b0010, "auto_low");
    expect_at(S + W + 1, 0, 4'b0011, "auto_release");
    expect_at(S + W + 1, 1, 4'b0001, "auto_done");
    expect_at(S + W + 1, 4, 4'b0001, "auto_rc_kept");
    tick(1);
    fault_n = 2'b11;
    tick(S + W + 9);

    auto_retry_en = 1'b0;
    fault_n       = 2'b10;
    expect_at(1, 2, 4'b0000, "noauto_busy");
    expect_at(1, 0, 4'b0011, "noauto_out");
    expect_at(1, 4, 4'b0001, "noauto_rc");
    tick(1);
    fault_n = 2'b11;
    tick(3);

    // Restart 20 cycles into a fast pulse with slow mode
    slow_reset  = 2'b00;
    reset_start = 2'b01;
    tick(1);
    reset_start = 2'b00;
    tick(19);
    slow_reset  = 2'b01;
    reset_start = 2'b01;
    expect_span(1, S + W, 0, 4'b0010, "restart_low");
    expect_at(S + W + 1, 0, 4'b0011, "restart_release");
    expect_at(1, 4, 4'b0000, "restart_rc");
    expect_at(S, 2, 4'b0001, "restart_busy");
    expect_at(S, 5, 4'b0010, "restart_w0_low");
    expect_at(S + 1, 5, 4'b0011, "restart_w0_release");
    tick(1);
    reset_start = 2'b00;
    slow_reset  = 2'b00;
    tick(S + W + 9);

    // Restart from SETTLE returns to a slow PULSE
    reset_start = 2'b01;
    tick(1);
    reset_start = 2'b00;
    tick(F + 9);
    check(2, 4'b0001, "settle_busy");
    slow_reset  = 2'b01;
    reset_start = 2'b01;
    expect_span(1, S + W, 0, 4'b0010, "settle_restart_low");
    expect_at(S + W + 1, 0, 4'b0011, "settle_restart_release");
    expect_at(S + W + 1, 1, 4'b0001, "settle_restart_done");
    tick(1);
    reset_start = 2'b00;
    slow_reset  = 2'b00;
    tick(S + W + 9);

    // Async reset in the middle of simultaneous pulses
    reset_start = 2'b11;
    tick(1);
    reset_start = 2'b00;
    tick(10);
    check(2, 4'b0011, "both_busy");
    check(0, 4'b0000, "both_out_low");
    #2 reset_n = 1'b0;
    #1;
    check(0, 4'b0011, "arst_out");
    check(2, 4'b0000, "arst_busy");
    check(1, 4'b0000, "arst_done");
    check(3, 4'b0000, "arst_lock");
    check(4, 4'b0000, "arst_rc");
    check(5, 4'b0011, "arst_w0_out");
    tick(2);
    reset_n = 1'b1;
    tick(2);

    while (sb.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL %s: never reached, due cycle %0d, now %0d", sb[0].tag, sb[0].cyc, cyc);
      void'(sb.pop_front());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
